// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the pipeline and the HI/LO multiply-divide unit.
// No latency of its own; pure wiring.
// Upstream holds op_valid while stall is high; the unit never queues requests.
interface muldiv_unit_if;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        mf_req;
    logic        flush;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        done;

    modport master (
        output op_valid, op, rs_data, rt_data, mf_req, flush,
        input  hi, lo, busy, stall, done
    );

    modport slave (
        input  op_valid, op, rs_data, rt_data, mf_req, flush,
        output hi, lo, busy, stall, done
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit owning the HI and LO registers.
// MULT/DIV: 33 busy cycles (32 CALC steps + 1 FIX), done pulses the cycle after; MTHI/MTLO land at the accepting edge.
// While busy, requests are not taken and stall asks upstream to hold; flush aborts without touching HI/LO.
module muldiv_unit #(
    parameter logic [31:0] HILO_RESET = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state;
    state_t      state_nxt;

    // acc: upper product half (multiply) or partial remainder (divide)
    // mq : multiplier shifting out / dividend shifting out, quotient shifting in
    // opb: multiplicand or divisor magnitude
    logic [31:0] acc;
    logic [31:0] mq;
    logic [31:0] opb;
    logic [4:0]  cnt;
    logic        is_div;
    logic        neg_q;
    logic        neg_r;
    logic        div_zero;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;

    logic        accept;
    logic        start;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [63:0] prod;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    assign accept = (state == IDLE) && bus.op_valid && !bus.flush;
    assign start  = accept && !bus.op[2];

    // Signed ops (op[0]==0) work on magnitudes; unsigned ops take the raw values.
    assign a_neg = !bus.op[0] && bus.rs_data[31];
    assign b_neg = !bus.op[0] && bus.rt_data[31];
    assign a_mag = a_neg ? (32'd0 - bus.rs_data) : bus.rs_data;
    assign b_mag = b_neg ? (32'd0 - bus.rt_data) : bus.rt_data;

    // One multiply step adds the multiplicand when the low multiplier bit is set, then shifts right.
    assign mul_sum = {1'b0, acc} + (mq[0] ? {1'b0, opb} : 33'd0);

    // One restoring divide step: bring the next dividend bit into the remainder and try the subtract.
    assign div_shift = {acc, mq[31]};
    assign div_ge    = div_shift >= {1'b0, opb};

    // Sign correction applied in FIX. A zero divisor keeps the all-ones quotient unnegated;
    // negating the remainder magnitude reproduces the original dividend.
    assign prod     = {acc, mq};
    assign prod_fix = neg_q ? (64'd0 - prod) : prod;
    assign quot_fix = (neg_q && !div_zero) ? (32'd0 - mq) : mq;
    assign rem_fix  = neg_r ? (32'd0 - acc) : acc;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: 32 CALC steps counted down from 31, one FIX cycle, flush aborts.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (bus.flush) state_nxt = IDLE;
                     else if (cnt == 5'd0) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and HI/LO writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= 32'd0;
            mq       <= 32'd0;
            opb      <= 32'd0;
            cnt      <= 5'd0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi_q     <= HILO_RESET;
            lo_q     <= HILO_RESET;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state == FIX) && !bus.flush;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= 32'd0;
                        mq       <= a_mag;
                        opb      <= b_mag;
                        cnt      <= 5'd31;
                        is_div   <= bus.op[1];
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        div_zero <= (bus.rt_data == 32'd0);
                    end
                    if (accept && bus.op == 3'b100) hi_q <= bus.rs_data;
                    if (accept && bus.op == 3'b101) lo_q <= bus.rs_data;
                end
                CALC: begin
                    if (!bus.flush) begin
                        cnt <= cnt - 5'd1;
                        if (is_div) begin
                            acc <= div_ge ? (div_shift[31:0] - opb) : div_shift[31:0];
                            mq  <= {mq[30:0], div_ge};
                        end else begin
                            acc <= mul_sum[32:1];
                            mq  <= {mul_sum[0], mq[31:1]};
                        end
                    end
                end
                FIX: begin
                    if (!bus.flush) begin
                        if (is_div) begin
                            hi_q <= rem_fix;
                            lo_q <= quot_fix;
                        end else begin
                            hi_q <= prod_fix[63:32];
                            lo_q <= prod_fix[31:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.busy  = (state != IDLE);
    assign bus.stall = (state != IDLE) && (bus.op_valid || bus.mf_req);
    assign bus.done  = done_q;
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter HILO_RESET, default 32'h0000_0000, reset value of HI and LO.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port op_valid  input  1  operation request this cycle.
REQ-005 SHALL have port op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 no-op.
REQ-006 SHALL have port rs_data  input  32  operand A (dividend / multiplicand / MTxx source), from the register-file read port.
REQ-007 SHALL have port rt_data  input  32  operand B (divisor / multiplier).
REQ-008 SHALL have port mf_req  input  1  MFHI/MFLO in decode wants HI/LO this cycle.
REQ-009 SHALL have port flush  input  1  abort the in-flight operation (exception/redirect).
REQ-010 SHALL have port hi  output  32  HI register.
REQ-011 SHALL have port lo  output  32  LO register.
REQ-012 SHALL have port busy  output  1  multiply/divide in progress.
REQ-013 SHALL have port stall  output  1  combinational: busy && (op_valid || mf_req).
REQ-014 SHALL have port done  output  1  one-cycle pulse when MULT/DIV results land in HI/LO.

Function
REQ-015 SHALL use three states: IDLE, CALC, FIX.
REQ-016 SHALL accept an op only when state==IDLE, op_valid=1, flush=0, rst=0.
REQ-017 SHALL ignore op_valid while busy; stall=1 and upstream holds the op.
REQ-018 SHALL latch rs_data/rt_data on accept; later input changes SHALL NOT affect the result.
REQ-019 MTHI/MTLO SHALL write rs_data to hi/lo at the accepting edge, leave the other register unchanged, and assert neither busy nor done.
REQ-020 MULT/DIV accept SHALL go IDLE->CALC, load operand magnitudes (signed ops) or raw values (unsigned ops), record result signs, and set a 5-bit counter to 31.
REQ-021 CALC SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle, decrement the counter, and go CALC->FIX after the counter==0 step (32 CALC cycles).
REQ-022 FIX SHALL apply sign correction, write hi/lo at the FIX edge, and go FIX->IDLE.
REQ-023 busy SHALL be 1 exactly in CALC and FIX (33 cycles per op).
REQ-024 done SHALL be 1 for exactly the first IDLE cycle after FIX; hi/lo show the new values in that same cycle.
REQ-025 Multiply SHALL produce {hi,lo} = the full 64-bit product, signed for MULT and unsigned for MULTU.
REQ-026 Divide SHALL produce lo = quotient truncated toward zero and hi = remainder carrying the sign of the dividend.
REQ-027 Divide by zero SHALL still take 33 cycles and yield hi = dividend and lo = 32'hFFFF_FFFF.
REQ-028 DIV 0x8000_0000 / 0xFFFF_FFFF SHALL yield lo = 0x8000_0000 and hi = 0.
REQ-029 flush in CALC or FIX SHALL return to IDLE at the next edge with hi/lo unchanged and no done.
REQ-030 flush in IDLE SHALL block acceptance that cycle, including MTHI/MTLO.
REQ-031 hi/lo SHALL change only via REQ-019, REQ-022 or reset.

Reset
REQ-032 When rst=1 at a clock edge: state=IDLE, hi=lo=HILO_RESET, busy=0, done=0, counter=0; an in-flight op is discarded.
REQ-033 rst SHALL take priority over flush and op_valid.
REQ-034 stall SHALL be 0 while in reset state.

Verification
REQ-035 Reset: assert rst 2 cycles -> hi=lo=0, busy=0, done=0, stall=0.
REQ-036 MULT rs=0xFFFF_FFFF, rt=2 -> busy 33 cycles, then done pulse with hi=0xFFFF_FFFF, lo=0xFFFF_FFFE. MULTU with the same operands -> hi=0x1, lo=0xFFFF_FFFE.
REQ-037 DIV rs=0xFFFF_FFF9 (-7), rt=2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. DIVU rs=7, rt=0 -> hi=7, lo=0xFFFF_FFFF.
REQ-038 DIV 0x8000_0000 / 0xFFFF_FFFF -> lo=0x8000_0000, hi=0, no hang, busy drops after 33 cycles.
REQ-039 Start MULTU 3*5, raise op_valid (MTHI) and mf_req at busy cycle 5 -> stall=1 and MTHI not taken. Flush at busy cycle 10 -> busy=0 next cycle, hi/lo unchanged, no done.
REQ-040 MTHI rs=0x1234 in IDLE -> hi=0x1234 next cycle, lo unchanged, busy=0, done=0.
